// File: rtl/inst_mem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Covers bus widths, handshake levels and the LOAD/RUN state encoding.
package inst_mem_resp_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   localparam logic [InstBus-1:0] ZeroWord = '0;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   localparam logic Stop        = 1'b1;
   localparam logic NoStop      = 1'b0;
   localparam logic RstEnable   = 1'b1;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/inst_mem_ram.sv
// Single-port synchronous RAM with registered read data.
// Contents and read register are never reset.
module inst_mem_ram #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [2**AW];
   logic [31:0] rdata_q;

   // Write on we, register the addressed word whenever enabled
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem[addr_i] <= wdata_i;
         end
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-fetch responder: boot loader into RAM, then
// one-cycle-latency fetch with a single-word hit register.
module inst_mem_resp
   import inst_mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter bit BOOT_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce_i,
   input  logic [31:0]           addr_i,
   output logic [31:0]           inst_o,
   output logic                  stall_req_o,
   input  logic                  load_valid_i,
   input  logic [7:0]            load_byte_i,
   input  logic                  load_done_i,
   output logic                  load_busy_o,
   output logic [DEPTH_LOG2:0]   load_words_o,
   output logic                  load_ovf_o
);

   localparam int AW = DEPTH_LOG2;
   localparam state_e StInit = BOOT_EN ? LOAD : RUN;

   state_e        state_q, state_d;
   logic [31:0]   asm_q, asm_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   words_q, words_d;
   logic          ovf_q, ovf_d;
   logic          hit_q, hit_d;
   logic [AW-1:0] hidx_q, hidx_d;
   logic          hoor_q, hoor_d;

   logic [31:0]   asm_nx;
   logic [1:0]    cnt_nx;
   logic          full, part;

   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata, ram_rdata;

   logic [AW-1:0] idx;
   logic          oor;
   logic          unused_addr;

   assign idx = addr_i[AW+1:2];
   assign oor = |addr_i[31:AW+2];
   assign unused_addr = ^addr_i[1:0];

   inst_mem_ram #(.AW(AW)) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // Next-state, boot assembler, RAM port and fetch response
   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      words_d     = words_q;
      ovf_d       = ovf_q;
      hit_d       = hit_q;
      hidx_d      = hidx_q;
      hoor_d      = hoor_q;
      asm_nx      = asm_q;
      cnt_nx      = cnt_q;
      full        = 1'b0;
      part        = 1'b0;
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = idx;
      ram_wdata   = asm_q;
      inst_o      = ZeroWord;
      stall_req_o = NoStop;
      load_busy_o = 1'b0;

      unique case (state_q)
         LOAD: begin
            stall_req_o = Stop;
            load_busy_o = 1'b1;
            if (load_valid_i) begin
               unique case (cnt_q)
                  2'd0: asm_nx[31:24] = load_byte_i;
                  2'd1: asm_nx[23:16] = load_byte_i;
                  2'd2: asm_nx[15:8]  = load_byte_i;
                  2'd3: asm_nx[7:0]   = load_byte_i;
               endcase
               cnt_nx = cnt_q + 2'd1;
            end
            full      = load_valid_i && (cnt_q == 2'd3);
            part      = load_done_i && (cnt_nx != 2'd0);
            ram_addr  = ptr_q;
            ram_wdata = asm_nx;
            if (full || part) begin
               ram_en  = 1'b1;
               ram_we  = 1'b1;
               ptr_d   = ptr_q + 1'b1;
               words_d = words_q + 1'b1;
               if (ptr_q == '1) begin
                  ovf_d = 1'b1;
               end
            end
            asm_d = full ? '0 : asm_nx;
            cnt_d = cnt_nx;
            if (load_done_i) begin
               asm_d   = '0;
               cnt_d   = 2'd0;
               hit_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (ce_i == ChipEnable) begin
               if (hit_q && (hidx_q == idx) && (hoor_q == oor)) begin
                  inst_o = hoor_q ? ZeroWord : ram_rdata;
               end else begin
                  stall_req_o = Stop;
                  ram_en      = 1'b1;
                  hit_d       = 1'b1;
                  hidx_d      = idx;
                  hoor_d      = oor;
               end
            end
         end
      endcase
   end

   // State registers; RAM contents deliberately untouched by reset
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= StInit;
         asm_q   <= '0;
         cnt_q   <= 2'd0;
         ptr_q   <= '0;
         words_q <= '0;
         ovf_q   <= 1'b0;
         hit_q   <= 1'b0;
         hidx_q  <= '0;
         hoor_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         asm_q   <= asm_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         words_q <= words_d;
         ovf_q   <= ovf_d;
         hit_q   <= hit_d;
         hidx_q  <= hidx_d;
         hoor_q  <= hoor_d;
      end
   end

   assign load_words_o = words_q;
   assign load_ovf_o   = ovf_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Directed bench for inst_mem_resp: boot load, fetch stalls,
// out-of-range, mid-stall retarget, reset mid-load, wrap.
module tb_inst_mem_resp;

   localparam int DL    = 10;
   localparam int DEPTH = 1 << DL;

   logic          clk;
   logic          rst;
   logic          ce_i;
   logic [31:0]   addr_i;
   logic [31:0]   inst_o;
   logic          stall_req_o;
   logic          load_valid_i;
   logic [7:0]    load_byte_i;
   logic          load_done_i;
   logic          load_busy_o;
   logic [DL:0]   load_words_o;
   logic          load_ovf_o;

   int tests;
   int fails;
   logic [31:0] sb[$];

   inst_mem_resp #(.DEPTH_LOG2(DL), .BOOT_EN(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .ce_i         (ce_i),
      .addr_i       (addr_i),
      .inst_o       (inst_o),
      .stall_req_o  (stall_req_o),
      .load_valid_i (load_valid_i),
      .load_byte_i  (load_byte_i),
      .load_done_i  (load_done_i),
      .load_busy_o  (load_busy_o),
      .load_words_o (load_words_o),
      .load_ovf_o   (load_ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [31:0] e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk(tag, inst_o, e);
      end
   endtask

   function automatic logic [7:0] pat(input int k);
      logic [31:0] v;
      v = k * 7 + 3;
      return v[7:0];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic lb(input logic [7:0] b, input logic d);
      load_valid_i = 1'b1;
      load_byte_i  = b;
      load_done_i  = d;
      @(posedge clk);
      #1;
      load_valid_i = 1'b0;
      load_done_i  = 1'b0;
   endtask

   task automatic ld_done();
      load_done_i = 1'b1;
      @(posedge clk);
      #1;
      load_done_i = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp,
                        input int exp_st, input string tag);
      int  st;
      bit  fin;
      sb.push_back(exp);
      ce_i   = 1'b1;
      addr_i = a;
      st     = 0;
      fin    = 1'b0;
      while (!fin) begin
         @(negedge clk);
         if (stall_req_o === 1'b0) begin
            fin = 1'b1;
         end else begin
            st++;
            if (st > 8) begin
               fin = 1'b1;
            end else begin
               @(posedge clk);
               #1;
            end
         end
      end
      chk({tag, "_stalls"}, st, exp_st);
      pop_chk(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] w0, w1, wl;
      tests        = 0;
      fails        = 0;
      rst          = 1'b1;
      ce_i         = 1'b1;
      addr_i       = '0;
      load_valid_i = 1'b0;
      load_byte_i  = '0;
      load_done_i  = 1'b0;

      do_reset();
      @(negedge clk);
      chk("rst_stall", stall_req_o, 1'b1);
      chk("rst_busy", load_busy_o, 1'b1);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_words", load_words_o, 0);
      chk("rst_ovf", load_ovf_o, 1'b0);
      @(posedge clk);
      #1;

      lb(8'h34, 0); lb(8'h02, 0); lb(8'h00, 0); lb(8'h01, 0);
      lb(8'h34, 0); lb(8'h03, 0); lb(8'h00, 0); lb(8'h02, 0);
      @(negedge clk);
      chk("load_inst_zero", inst_o, 32'h0);
      @(posedge clk);
      #1;
      ce_i = 1'b0;
      ld_done();
      @(negedge clk);
      chk("l1_words", load_words_o, 2);
      chk("l1_busy", load_busy_o, 1'b0);
      chk("ce0_stall", stall_req_o, 1'b0);
      chk("ce0_inst", inst_o, 32'h0);
      @(posedge clk);
      #1;

      fetch(32'h0, 32'h3402_0001, 1, "f0");
      fetch(32'h4, 32'h3403_0002, 1, "f4");
      fetch(32'h5, 32'h3403_0002, 0, "f5");

      fetch(32'h0010_0000, 32'h0, 1, "oor");
      ce_i = 1'b0;
      @(negedge clk);
      chk("ce0b_inst", inst_o, 32'h0);
      chk("ce0b_stall", stall_req_o, 1'b0);
      @(posedge clk);
      #1;

      ce_i   = 1'b1;
      addr_i = 32'h0;
      @(negedge clk);
      chk("retgt_st0", stall_req_o, 1'b1);
      @(posedge clk);
      #1;
      addr_i = 32'h4;
      sb.push_back(32'h3403_0002);
      @(negedge clk);
      chk("retgt_st1", stall_req_o, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("retgt_st2", stall_req_o, 1'b0);
      pop_chk("retgt_inst");
      @(posedge clk);
      #1;

      ce_i = 1'b0;
      do_reset();
      lb(8'hAA, 0); lb(8'hBB, 0); lb(8'hCC, 0); lb(8'hDD, 0);
      lb(8'hEE, 1);
      @(negedge clk);
      chk("pad_words", load_words_o, 2);
      @(posedge clk);
      #1;
      fetch(32'h0, 32'hAABB_CCDD, 1, "pad_w0");
      fetch(32'h4, 32'hEE00_0000, 1, "pad_w1");

      ce_i = 1'b0;
      do_reset();
      for (int i = 1; i <= 6; i++) lb(i[7:0], 0);
      do_reset();
      @(negedge clk);
      chk("midrst_words", load_words_o, 0);
      @(posedge clk);
      #1;
      lb(8'h11, 0); lb(8'h22, 0); lb(8'h33, 0); lb(8'h44, 0);
      ld_done();
      @(negedge clk);
      chk("midrst_words1", load_words_o, 1);
      @(posedge clk);
      #1;
      fetch(32'h0, 32'h1122_3344, 1, "midrst_w0");
      fetch(32'h4, 32'hEE00_0000, 1, "midrst_w1");

      ce_i = 1'b0;
      do_reset();
      for (int k = 0; k < DEPTH * 4 + 4; k++) lb(pat(k), 0);
      @(negedge clk);
      chk("ovf_flag", load_ovf_o, 1'b1);
      chk("ovf_words", load_words_o, DEPTH + 1);
      @(posedge clk);
      #1;
      ld_done();
      w0 = {pat(DEPTH * 4), pat(DEPTH * 4 + 1),
            pat(DEPTH * 4 + 2), pat(DEPTH * 4 + 3)};
      w1 = {pat(4), pat(5), pat(6), pat(7)};
      wl = {pat(DEPTH * 4 - 4), pat(DEPTH * 4 - 3),
            pat(DEPTH * 4 - 2), pat(DEPTH * 4 - 1)};
      fetch(32'h0, w0, 1, "ovf_w0");
      fetch(32'h4, w1, 1, "ovf_w1");
      fetch((DEPTH - 1) * 4, wl, 1, "ovf_wlast");
      @(negedge clk);
      chk("ovf_words_run", load_words_o, DEPTH + 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Responder (memory) end of the instruction-fetch interface: the CPU drives chip-enable and address, and this block returns the instruction.
- Replaces the combinational instruction ROM with a synchronous single-port RAM, so reads take one cycle. The block holds the CPU off with a stall request until the addressed word is available.
- After reset it accepts a byte-serial boot image and writes it into the RAM before serving fetches.
- Sits between the CPU fetch port and the boot-load source in the minimal SOPC.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words).
- BOOT_EN, 1, when 1 the block enters LOAD after reset; when 0 it enters RUN directly.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ce_i  in  1  fetch chip-enable from the CPU.
- addr_i  in  32  fetch byte address from the CPU.
- inst_o  out  32  instruction for addr_i; valid when ce_i=1 and stall_req_o=0.
- stall_req_o  out  1  CPU must hold addr_i and freeze fetch while this is 1.
- load_valid_i  in  1  boot byte strobe.
- load_byte_i  in  8  boot byte.
- load_done_i  in  1  one-cycle pulse marking end of the boot image.
- load_busy_o  out  1  1 while in LOAD.
- load_words_o  out  DEPTH_LOG2+1  number of words written since the last reset.
- load_ovf_o  out  1  sticky; set when the write pointer wraps.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=LOAD if BOOT_EN else RUN; inst_o=0; stall_req_o=1 if BOOT_EN else 0; load_busy_o=BOOT_EN; load_words_o=0; load_ovf_o=0; hit register invalid; byte counter=0; write pointer=0.
- RAM contents are not reset and persist across rst.
- Word index = addr_i[DEPTH_LOG2+1:2]; addr_i[1:0] is ignored.
- Address out of range (any of addr_i[31:DEPTH_LOG2+2] nonzero): inst_o=0 (nop) once served; stall behaviour is unchanged.
- State LOAD:
  - stall_req_o=1 and inst_o=0 regardless of ce_i.
  - Each load_valid_i cycle shifts load_byte_i into a word assembler, first byte into bits 31:24 (big-endian).
  - On the 4th byte: write RAM[wr_ptr], then wr_ptr+1 and load_words_o+1.
  - When wr_ptr wraps from DEPTH-1 to 0, set load_ovf_o; writing continues and overwrites from word 0.
  - load_done_i with a partial word pending (1-3 bytes): write that word with the missing low bytes zero-padded, count it, then go to RUN.
  - load_valid_i and load_done_i in the same cycle: that byte is consumed first, then done is processed as above.
  - Next state after done is RUN, with the hit register invalid.
- State RUN:
  - load_valid_i and load_done_i are ignored.
  - ce_i=0: inst_o=0, stall_req_o=0, no RAM read.
  - ce_i=1 and hit valid and held index == current index and held range flag matches: inst_o=held data, stall_req_o=0 (same cycle).
  - ce_i=1 otherwise (miss): stall_req_o=1 and inst_o=0. The RAM is read at the current index this cycle; the next cycle the held data, index and range flag update and the hit becomes valid.
  - Sequential fetch cost: 1 stall cycle plus 1 serve cycle per new word. Repeated fetch of the same word costs 0 stall cycles.
  - If addr_i changes while stalled, the read is re-issued for the new index; no stale data is ever served.
- Reset mid-LOAD: partial word discarded, wr_ptr=0, load_words_o=0; words already written remain in RAM.
- Reset mid-RUN: hit register invalidated; next state per BOOT_EN.

Decomposition:
- Shared defines include: InstAddrBus, InstBus, ZeroWord, ChipEnable/ChipDisable, Stop/NoStop, RstEnable, and state encodings LOAD=1'b0, RUN=1'b1.
- Sub-module inst_mem_ram: single-port synchronous RAM, DEPTH_LOG2-bit address, 32-bit data, write enable, registered read data, no reset.
- inst_mem_resp contains the FSM, byte assembler, write pointer, hit register and stall logic.

Test Plan:
- Reset with BOOT_EN=1, ce_i=1 -> stall_req_o=1, load_busy_o=1, inst_o=0, load_words_o=0.
- Load bytes 34 02 00 01, 34 03 00 02, then load_done_i -> load_words_o=2, state RUN. Fetch 0x0 -> 1 stall cycle, then inst_o=0x34020001. Fetch 0x4 -> 1 stall cycle, then inst_o=0x34030002. Fetch 0x5 -> inst_o=0x34030002 with no stall.
- Load 5 bytes AA BB CC DD EE with load_done_i on the 5th byte's cycle -> word1=0xEE000000, load_words_o=2.
- Load DEPTH*4+4 bytes -> load_ovf_o=1, word0 = last 4 bytes, load_words_o=DEPTH+1.
- RUN with ce_i=1: addr_i=0x00100000 -> 1 stall, then inst_o=0. ce_i=0 -> inst_o=0, stall_req_o=0. addr_i changed mid-stall -> data returned is for the new address.
- Assert rst after 6 bytes of a load, then reload 4 bytes 11 22 33 44 -> word0=0x11223344, word1 keeps its pre-reset value, load_words_o=1.
